// File: rtl/pipelined_decode.sv
// LEGv8 decode stage: register file with write-back bypass, control decode,
// immediate extraction and a single output register with load-use interlock.
module pipelined_decode #(
    parameter int WORD      = 64,
    parameter int REG_COUNT = 32,
    parameter int INSTR_LEN = 32,
    parameter int RIDX      = $clog2(REG_COUNT)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [INSTR_LEN-1:0] instruction,
    output logic                 in_ready,
    input  logic                 wb_en,
    input  logic [RIDX-1:0]      wb_reg,
    input  logic [WORD-1:0]      wb_data,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [10:0]          out_opcode,
    output logic [WORD-1:0]      out_read_data1,
    output logic [WORD-1:0]      out_read_data2,
    output logic [WORD-1:0]      out_imm,
    output logic [RIDX-1:0]      out_rd,
    output logic                 out_uncond_branch,
    output logic                 out_branch,
    output logic                 out_mem_read,
    output logic                 out_mem_to_reg,
    output logic                 out_mem_write,
    output logic                 out_alu_src,
    output logic                 out_reg_write,
    output logic                 out_illegal,
    output logic [1:0]           out_alu_op,
    output logic [15:0]          stall_count
);

    localparam logic [RIDX-1:0] XZR = RIDX'(REG_COUNT - 1);

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;

    logic [WORD-1:0] r_regs [REG_COUNT];

    logic            r_valid;
    logic [10:0]     r_opcode;
    logic [WORD-1:0] r_rdata1, r_rdata2, r_imm;
    logic [RIDX-1:0] r_rd;
    logic            r_uncond, r_branch, r_mem_read, r_mem_to_reg;
    logic            r_mem_write, r_alu_src, r_reg_write, r_illegal;
    logic [1:0]      r_alu_op;
    logic [15:0]     r_stall;

    logic [10:0]     w_opcode;
    logic [RIDX-1:0] w_rn, w_rs2, w_rd;
    logic [WORD-1:0] w_rdata1, w_rdata2, w_imm;
    logic            w_uncond, w_branch, w_mem_read, w_mem_to_reg;
    logic            w_mem_write, w_alu_src, w_reg_write, w_illegal, w_use_rd;
    logic [1:0]      w_alu_op;
    logic            w_hazard, w_xfer;

    assign w_opcode = instruction[31:21];
    assign w_rn     = RIDX'(instruction[9:5]);
    assign w_rd     = RIDX'(instruction[4:0]);

    always_comb begin
        w_reg_write  = 1'b0;
        w_alu_src    = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_to_reg = 1'b0;
        w_mem_write  = 1'b0;
        w_branch     = 1'b0;
        w_uncond     = 1'b0;
        w_alu_op     = 2'b00;
        w_illegal    = 1'b0;
        w_use_rd     = 1'b0;
        w_imm        = '0;
        if (w_opcode == OP_ADD || w_opcode == OP_SUB ||
            w_opcode == OP_AND || w_opcode == OP_ORR) begin
            w_reg_write = 1'b1;
            w_alu_op    = 2'b10;
        end else if (w_opcode == OP_LDUR) begin
            w_reg_write  = 1'b1;
            w_alu_src    = 1'b1;
            w_mem_read   = 1'b1;
            w_mem_to_reg = 1'b1;
            w_imm        = {{(WORD-9){instruction[20]}}, instruction[20:12]};
        end else if (w_opcode == OP_STUR) begin
            w_alu_src   = 1'b1;
            w_mem_write = 1'b1;
            w_use_rd    = 1'b1;
            w_imm       = {{(WORD-9){instruction[20]}}, instruction[20:12]};
        end else if (w_opcode[10:3] == 8'b10110100) begin
            w_branch = 1'b1;
            w_alu_op = 2'b01;
            w_use_rd = 1'b1;
            w_imm    = {{(WORD-19){instruction[23]}}, instruction[23:5]};
        end else if (w_opcode[10:5] == 6'b000101) begin
            w_uncond = 1'b1;
            w_imm    = {{(WORD-26){instruction[25]}}, instruction[25:0]};
        end else begin
            w_illegal = 1'b1;
        end
    end

    // Store and CBZ read their data/test register through the rd field.
    assign w_rs2 = w_use_rd ? w_rd : RIDX'(instruction[20:16]);

    assign w_rdata1 = (w_rn == XZR) ? '0 :
                      (wb_en && wb_reg == w_rn) ? wb_data : r_regs[w_rn];
    assign w_rdata2 = (w_rs2 == XZR) ? '0 :
                      (wb_en && wb_reg == w_rs2) ? wb_data : r_regs[w_rs2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= '0;
        end else if (wb_en && wb_reg != XZR) begin
            r_regs[wb_reg] <= wb_data;
        end
    end

    // A load in the output register whose destination is needed now stalls one cycle.
    assign w_hazard = r_valid && r_mem_read && (r_rd != XZR) &&
                      ((w_rn == r_rd) || (w_rs2 == r_rd));
    assign in_ready = flush || ((!r_valid || out_ready) && !w_hazard);
    assign w_xfer   = in_valid && in_ready;

    // ---- output register stage ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_xfer) begin
            r_valid <= 1'b1;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opcode     <= '0;
            r_rdata1     <= '0;
            r_rdata2     <= '0;
            r_imm        <= '0;
            r_rd         <= '0;
            r_uncond     <= 1'b0;
            r_branch     <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_mem_write  <= 1'b0;
            r_alu_src    <= 1'b0;
            r_reg_write  <= 1'b0;
            r_illegal    <= 1'b0;
            r_alu_op     <= 2'b00;
        end else if (!flush && w_xfer) begin
            r_opcode     <= w_opcode;
            r_rdata1     <= w_rdata1;
            r_rdata2     <= w_rdata2;
            r_imm        <= w_imm;
            r_rd         <= w_rd;
            r_uncond     <= w_uncond;
            r_branch     <= w_branch;
            r_mem_read   <= w_mem_read;
            r_mem_to_reg <= w_mem_to_reg;
            r_mem_write  <= w_mem_write;
            r_alu_src    <= w_alu_src;
            r_reg_write  <= w_reg_write;
            r_illegal    <= w_illegal;
            r_alu_op     <= w_alu_op;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall <= '0;
        end else if (in_valid && w_hazard && out_ready && r_stall != 16'hFFFF) begin
            r_stall <= r_stall + 16'd1;
        end
    end

    assign out_valid         = r_valid;
    assign out_opcode        = r_opcode;
    assign out_read_data1    = r_rdata1;
    assign out_read_data2    = r_rdata2;
    assign out_imm           = r_imm;
    assign out_rd            = r_rd;
    assign out_uncond_branch = r_uncond;
    assign out_branch        = r_branch;
    assign out_mem_read      = r_mem_read;
    assign out_mem_to_reg    = r_mem_to_reg;
    assign out_mem_write     = r_mem_write;
    assign out_alu_src       = r_alu_src;
    assign out_reg_write     = r_reg_write;
    assign out_illegal       = r_illegal;
    assign out_alu_op        = r_alu_op;
    assign stall_count       = r_stall;

endmodule

// File: tb/tb_pipelined_decode.sv
// Bench for pipelined_decode: directed scenarios plus a randomized run against a
// transaction-level reference model of the decode stage.
module tb_pipelined_decode;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;

    typedef struct packed {
        logic [10:0] opcode;
        logic [63:0] rd1;
        logic [63:0] rd2;
        logic [63:0] imm;
        logic [4:0]  rd;
        logic        uncond;
        logic        branch;
        logic        mem_read;
        logic        mem_to_reg;
        logic        mem_write;
        logic        alu_src;
        logic        reg_write;
        logic        illegal;
        logic [1:0]  alu_op;
    } bundle_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] instruction = '0;
    logic        in_ready;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_reg = '0;
    logic [63:0] wb_data = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [10:0] out_opcode;
    logic [63:0] out_read_data1, out_read_data2, out_imm;
    logic [4:0]  out_rd;
    logic        out_uncond_branch, out_branch, out_mem_read, out_mem_to_reg;
    logic        out_mem_write, out_alu_src, out_reg_write, out_illegal;
    logic [1:0]  out_alu_op;
    logic [15:0] stall_count;

    bundle_t dut_b;
    assign dut_b = {out_opcode, out_read_data1, out_read_data2, out_imm, out_rd,
                    out_uncond_branch, out_branch, out_mem_read, out_mem_to_reg,
                    out_mem_write, out_alu_src, out_reg_write, out_illegal, out_alu_op};

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [63:0] m_regs [32];
    logic        m_valid;
    bundle_t     m_b;
    logic [15:0] m_stall;

    pipelined_decode dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .instruction(instruction),
        .in_ready(in_ready), .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_read_data1(out_read_data1),
        .out_read_data2(out_read_data2), .out_imm(out_imm), .out_rd(out_rd),
        .out_uncond_branch(out_uncond_branch), .out_branch(out_branch),
        .out_mem_read(out_mem_read), .out_mem_to_reg(out_mem_to_reg),
        .out_mem_write(out_mem_write), .out_alu_src(out_alu_src),
        .out_reg_write(out_reg_write), .out_illegal(out_illegal),
        .out_alu_op(out_alu_op), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_read(input logic [4:0] idx);
        if (idx == 5'd31) return 64'd0;
        if (wb_en && wb_reg == idx) return wb_data;
        return m_regs[idx];
    endfunction

    function automatic longint sext(input longint v, input int bits);
        if (v >= (longint'(1) <<< (bits - 1))) return v - (longint'(1) <<< bits);
        return v;
    endfunction

    function automatic bundle_t ref_decode(input logic [31:0] ins);
        bundle_t b;
        logic [10:0] op;
        logic [4:0]  r2;
        b = '0;
        op = ins[31:21];
        b.opcode = op;
        b.rd = ins[4:0];
        if (op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_ORR) begin
            b.reg_write = 1; b.alu_op = 2'd2;
        end else if (op == OP_LDUR) begin
            b.reg_write = 1; b.alu_src = 1; b.mem_read = 1; b.mem_to_reg = 1;
            b.imm = sext(longint'(ins[20:12]), 9);
        end else if (op == OP_STUR) begin
            b.alu_src = 1; b.mem_write = 1;
            b.imm = sext(longint'(ins[20:12]), 9);
        end else if (op[10:3] == 8'hB4) begin
            b.branch = 1; b.alu_op = 2'd1;
            b.imm = sext(longint'(ins[23:5]), 19);
        end else if (op[10:5] == 6'b000101) begin
            b.uncond = 1;
            b.imm = sext(longint'(ins[25:0]), 26);
        end else begin
            b.illegal = 1;
        end
        r2 = (b.mem_write || b.branch) ? ins[4:0] : ins[20:16];
        b.rd1 = ref_read(ins[9:5]);
        b.rd2 = ref_read(r2);
        return b;
    endfunction

    function automatic logic ref_hazard(input logic [31:0] ins);
        bundle_t b;
        logic [4:0] r2;
        b = ref_decode(ins);
        r2 = (b.mem_write || b.branch) ? ins[4:0] : ins[20:16];
        return m_valid && m_b.mem_read && m_b.rd != 5'd31 &&
               (ins[9:5] == m_b.rd || r2 == m_b.rd);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_valid = 0;
        m_b = '0;
        m_stall = '0;
    endtask

    // Advance one clock, updating the model from the inputs present at the edge.
    task automatic clk_step();
        bundle_t nb;
        logic hz, xfer;
        hz = ref_hazard(instruction);
        xfer = in_valid && (flush || ((!m_valid || out_ready) && !hz));
        nb = ref_decode(instruction);
        @(posedge clk);
        if (flush) m_valid = 0;
        else if (xfer) begin m_b = nb; m_valid = 1; end
        else if (out_ready) m_valid = 0;
        if (in_valid && hz && out_ready && m_stall != 16'hFFFF) m_stall = m_stall + 1;
        if (wb_en && wb_reg != 5'd31) m_regs[wb_reg] = wb_data;
        #1;
    endtask

    function automatic logic [4:0] pick_reg();
        int k;
        k = $urandom_range(0, 4);
        return (k == 4) ? 5'd31 : 5'(k);
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0] a, b, c;
        a = pick_reg(); b = pick_reg(); c = pick_reg();
        case ($urandom_range(0, 8))
            0: return {OP_ADD, b, 6'($urandom), a, c};
            1: return {OP_SUB, b, 6'($urandom), a, c};
            2: return {OP_AND, b, 6'($urandom), a, c};
            3: return {OP_ORR, b, 6'($urandom), a, c};
            4: return {OP_LDUR, 9'($urandom), 2'b00, a, c};
            5: return {OP_STUR, 9'($urandom), 2'b00, a, c};
            6: return {8'hB4, 19'($urandom), c};
            7: return {6'b000101, 26'($urandom)};
            default: return {11'h7FF, 21'($urandom)};
        endcase
    endfunction

    task automatic wb_write(input logic [4:0] r, input logic [63:0] d);
        in_valid = 0; wb_en = 1; wb_reg = r; wb_data = d;
        clk_step();
        wb_en = 0;
    endtask

    task automatic test_reset();
        #1 rst_n = 0;
        model_reset();
        #2;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        checks++; if (dut_b !== '0) begin errors++; $display("FAIL reset_bundle: got %h expected 0", dut_b); end
        checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL reset_stall: got %0d expected 0", stall_count); end
        @(negedge clk) rst_n = 1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_add();
        wb_write(5'd1, 64'd5);
        wb_write(5'd2, 64'd7);
        out_ready = 1; in_valid = 1;
        instruction = {OP_ADD, 5'd2, 6'd0, 5'd1, 5'd3};
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL add_in_ready: got %b expected 1", in_ready); end
        clk_step();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %b expected 1", out_valid); end
        checks++; if (out_read_data1 !== 64'd5 || out_read_data2 !== 64'd7) begin errors++; $display("FAIL add_data: got %0d,%0d expected 5,7", out_read_data1, out_read_data2); end
        checks++; if (out_alu_op !== 2'b10 || out_reg_write !== 1'b1) begin errors++; $display("FAIL add_ctrl: got alu_op=%b rw=%b expected 10,1", out_alu_op, out_reg_write); end
        checks++; if (dut_b !== m_b) begin errors++; $display("FAIL add_bundle: got %h expected %h", dut_b, m_b); end
        in_valid = 0;
        clk_step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_load_use();
        out_ready = 1; in_valid = 1;
        instruction = {OP_LDUR, 9'h1F8, 2'b00, 5'd1, 5'd4};
        clk_step();
        checks++; if (out_valid !== 1'b1 || out_mem_read !== 1'b1) begin errors++; $display("FAIL ldur_out: got v=%b mr=%b expected 1,1", out_valid, out_mem_read); end
        checks++; if (out_imm !== 64'hFFFF_FFFF_FFFF_FFF8) begin errors++; $display("FAIL ldur_imm: got %h expected fffffffffffffff8", out_imm); end
        instruction = {OP_ADD, 5'd4, 6'd0, 5'd4, 5'd5};
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hazard_in_ready: got %b expected 0", in_ready); end
        clk_step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bubble_valid: got %b expected 0", out_valid); end
        checks++; if (stall_count !== 16'd1) begin errors++; $display("FAIL stall_count: got %0d expected 1", stall_count); end
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL after_bubble_ready: got %b expected 1", in_ready); end
        clk_step();
        checks++; if (out_valid !== 1'b1 || out_opcode !== OP_ADD || out_rd !== 5'd5) begin errors++; $display("FAIL add_after_load: got v=%b op=%h rd=%0d expected 1,%h,5", out_valid, out_opcode, out_rd, OP_ADD); end
        in_valid = 0;
        clk_step();
    endtask

    task automatic test_bypass();
        out_ready = 1; in_valid = 1;
        wb_en = 1; wb_reg = 5'd2; wb_data = 64'hAA;
        instruction = {OP_ADD, 5'd2, 6'd0, 5'd1, 5'd3};
        clk_step();
        checks++; if (out_read_data2 !== 64'hAA || out_read_data1 !== 64'd5) begin errors++; $display("FAIL bypass_x2: got %h,%h expected 5,aa", out_read_data1, out_read_data2); end
        wb_reg = 5'd31; wb_data = 64'h55; in_valid = 0;
        clk_step();
        wb_reg = 5'd31; wb_data = 64'h77; in_valid = 1;
        instruction = {OP_ADD, 5'd31, 6'd0, 5'd31, 5'd3};
        clk_step();
        checks++; if (out_read_data1 !== 64'd0 || out_read_data2 !== 64'd0) begin errors++; $display("FAIL xzr_read: got %h,%h expected 0,0", out_read_data1, out_read_data2); end
        wb_en = 0; in_valid = 0;
        clk_step();
    endtask

    task automatic test_backpressure();
        bundle_t held;
        out_ready = 1; in_valid = 1;
        instruction = {OP_ORR, 5'd2, 6'd0, 5'd1, 5'd6};
        clk_step();
        held = m_b;
        out_ready = 0;
        instruction = {OP_SUB, 5'd1, 6'd0, 5'd2, 5'd7};
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d]: got %b expected 0", i, in_ready); end
            clk_step();
            checks++; if (out_valid !== 1'b1 || dut_b !== held) begin errors++; $display("FAIL bp_hold[%0d]: got v=%b %h expected 1 %h", i, out_valid, dut_b, held); end
        end
        out_ready = 1;
        clk_step();
        checks++; if (out_valid !== 1'b1 || out_opcode !== OP_SUB || dut_b !== m_b) begin errors++; $display("FAIL bp_resume: got %h expected %h", dut_b, m_b); end
        instruction = {OP_AND, 5'd1, 6'd0, 5'd2, 5'd8};
        clk_step();
        checks++; if (out_valid !== 1'b1 || out_opcode !== OP_AND) begin errors++; $display("FAIL bp_next: got v=%b op=%h expected 1 %h", out_valid, out_opcode, OP_AND); end
        in_valid = 0;
        clk_step();
    endtask

    task automatic test_flush();
        out_ready = 0; in_valid = 1;
        instruction = {OP_ADD, 5'd2, 6'd0, 5'd1, 5'd9};
        clk_step();
        flush = 1;
        instruction = {OP_AND, 5'd2, 6'd0, 5'd1, 5'd10};
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b expected 1", in_ready); end
        clk_step();
        flush = 0; in_valid = 0; out_ready = 1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", out_valid); end
        clk_step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_emit: got %b expected 0", out_valid); end
    endtask

    task automatic test_illegal();
        out_ready = 1; in_valid = 1;
        instruction = {11'h7FF, 21'($urandom)};
        clk_step();
        checks++; if (out_valid !== 1'b1 || out_illegal !== 1'b1) begin errors++; $display("FAIL illegal_flag: got v=%b ill=%b expected 1,1", out_valid, out_illegal); end
        checks++; if ({out_uncond_branch, out_branch, out_mem_read, out_mem_to_reg, out_mem_write,
                       out_alu_src, out_reg_write, out_alu_op, out_imm} !== '0) begin errors++; $display("FAIL illegal_ctrl: got nonzero controls/imm %h expected 0", dut_b); end
        in_valid = 0;
        clk_step();
    endtask

    task automatic test_random();
        logic exp_ready;
        for (int n = 0; n < 400; n++) begin
            in_valid = ($urandom_range(0, 9) < 8);
            instruction = rand_instr();
            out_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 19) == 0);
            wb_en = 1'($urandom_range(0, 1));
            wb_reg = pick_reg();
            wb_data = {$urandom, $urandom};
            #1;
            exp_ready = flush || ((!m_valid || out_ready) && !ref_hazard(instruction));
            checks++; if (in_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready[%0d]: got %b expected %b", n, in_ready, exp_ready); end
            clk_step();
            checks++; if (out_valid !== m_valid) begin errors++; $display("FAIL rnd_valid[%0d]: got %b expected %b", n, out_valid, m_valid); end
            if (m_valid) begin
                checks++; if (dut_b !== m_b) begin errors++; $display("FAIL rnd_bundle[%0d]: got %h expected %h", n, dut_b, m_b); end
            end
            checks++; if (stall_count !== m_stall) begin errors++; $display("FAIL rnd_stall[%0d]: got %0d expected %0d", n, stall_count, m_stall); end
        end
        flush = 0; wb_en = 0; in_valid = 0; out_ready = 1;
        clk_step();
    endtask

    task automatic test_reset_midstream();
        out_ready = 1; in_valid = 1;
        instruction = {OP_LDUR, 9'h010, 2'b00, 5'd1, 5'd2};
        clk_step();
        #2 rst_n = 0;
        #1;
        checks++; if (out_valid !== 1'b0 || dut_b !== '0) begin errors++; $display("FAIL midrst_out: got v=%b %h expected 0", out_valid, dut_b); end
        checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL midrst_stall: got %0d expected 0", stall_count); end
        @(negedge clk) rst_n = 1;
        model_reset();
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b expected 1", in_ready); end
        instruction = {OP_ADD, 5'd2, 6'd0, 5'd1, 5'd3};
        clk_step();
        checks++; if (out_read_data1 !== 64'd0 || out_read_data2 !== 64'd0 || dut_b !== m_b) begin errors++; $display("FAIL midrst_regs: got %h expected %h", dut_b, m_b); end
        in_valid = 0;
        clk_step();
    endtask

    initial begin
        test_reset();
        test_add();
        test_load_use();
        test_bypass();
        test_backpressure();
        test_flush();
        test_illegal();
        test_random();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
